// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single RAM port between the instruction-refill (I) side and the
//   load/store (D) side of the 4-hart core. One transaction is in flight at a
//   time: IDLE arbitrates, WAIT holds the RAM strobes until RamReady or the
//   watchdog expires, and the following cycle (an IDLE cycle) carries the
//   tagged completion.
// Ports
//   clk, nReset                      clock, asynchronous active-low reset
//   IReq/IAddr/IHart/IFlush          I-side read request and squash
//   IGrant/IDone/IErr/IData/IDoneHart I-side accept pulse and completion
//   DReq/DWe/DAddr/DWData/DByteEn/DHart  D-side read/write request
//   DGrant/DDone/DErr/DRData/DDoneHart   D-side accept pulse and completion
//   RamRead/RamWrite/RamAddr/RamWData/RamByteEn  RAM strobes, held in WAIT
//   RamReady/RamRData                RAM completion and read data
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8,
    parameter bit          D_PRIORITY     = 1'b0
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    input  logic [1:0]  IHart,
    input  logic        IFlush,
    output logic        IGrant,
    output logic        IDone,
    output logic        IErr,
    output logic [31:0] IData,
    output logic [1:0]  IDoneHart,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    input  logic [3:0]  DByteEn,
    input  logic [1:0]  DHart,
    output logic        DGrant,
    output logic        DDone,
    output logic        DErr,
    output logic [31:0] DRData,
    output logic [1:0]  DDoneHart,
    output logic        RamRead,
    output logic        RamWrite,
    output logic [31:0] RamAddr,
    output logic [31:0] RamWData,
    output logic [3:0]  RamByteEn,
    input  logic        RamReady,
    input  logic [31:0] RamRData
);
    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {SIDE_I, SIDE_D} side_t;

    // Watchdog value of the last WAIT cycle that may still see RamReady.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state, stateNext;
    side_t                owner, ownerNext;
    side_t                lastGrant, lastGrantNext;
    logic                 squash, squashNext;
    logic [TIMEOUT_W-1:0] cnt, cntNext;
    logic [1:0]           hart, hartNext;

    logic        iGrantNext, iDoneNext, iErrNext;
    logic [31:0] iDataNext;
    logic [1:0]  iDoneHartNext;
    logic        dGrantNext, dDoneNext, dErrNext;
    logic [31:0] dRDataNext;
    logic [1:0]  dDoneHartNext;
    logic        ramReadNext, ramWriteNext;
    logic [31:0] ramAddrNext, ramWDataNext;
    logic [3:0]  ramByteEnNext;

    logic iCand, pickD, flushed, timedOut;

    assign iCand    = IReq & ~IFlush;
    assign pickD    = DReq & (~iCand | D_PRIORITY | (lastGrant == SIDE_I));
    // A flush seen in the completing cycle itself must still suppress IDone.
    assign flushed  = squash | ((owner == SIDE_I) & IFlush);
    assign timedOut = ~RamReady & (cnt == CNT_LAST);

    always_comb begin
        stateNext     = state;
        ownerNext     = owner;
        lastGrantNext = lastGrant;
        squashNext    = squash;
        cntNext       = cnt;
        hartNext      = hart;
        iGrantNext    = 1'b0;
        iDoneNext     = 1'b0;
        iErrNext      = 1'b0;
        iDataNext     = '0;
        iDoneHartNext = '0;
        dGrantNext    = 1'b0;
        dDoneNext     = 1'b0;
        dErrNext      = 1'b0;
        dRDataNext    = '0;
        dDoneHartNext = '0;
        ramReadNext   = RamRead;
        ramWriteNext  = RamWrite;
        ramAddrNext   = RamAddr;
        ramWDataNext  = RamWData;
        ramByteEnNext = RamByteEn;

        unique case (state)
            IDLE: begin
                if (iCand | DReq) begin
                    stateNext  = WAIT;
                    cntNext    = '0;
                    squashNext = 1'b0;
                    if (pickD) begin
                        ownerNext     = SIDE_D;
                        lastGrantNext = SIDE_D;
                        dGrantNext    = 1'b1;
                        ramReadNext   = ~DWe;
                        ramWriteNext  = DWe;
                        ramAddrNext   = DAddr;
                        ramWDataNext  = DWData;
                        ramByteEnNext = DByteEn;
                        hartNext      = DHart;
                    end else begin
                        ownerNext     = SIDE_I;
                        lastGrantNext = SIDE_I;
                        iGrantNext    = 1'b1;
                        ramReadNext   = 1'b1;
                        ramWriteNext  = 1'b0;
                        ramAddrNext   = IAddr;
                        ramWDataNext  = '0;
                        ramByteEnNext = 4'b1111;
                        hartNext      = IHart;
                    end
                end
            end
            WAIT: begin
                squashNext = flushed;
                if (RamReady | timedOut) begin
                    stateNext     = IDLE;
                    cntNext       = '0;
                    squashNext    = 1'b0;
                    ramReadNext   = 1'b0;
                    ramWriteNext  = 1'b0;
                    ramAddrNext   = '0;
                    ramWDataNext  = '0;
                    ramByteEnNext = '0;
                    if (owner == SIDE_D) begin
                        dDoneNext     = 1'b1;
                        dErrNext      = timedOut;
                        dRDataNext    = (RamWrite | timedOut) ? '0 : RamRData;
                        dDoneHartNext = hart;
                    end else if (!flushed) begin
                        iDoneNext     = 1'b1;
                        iErrNext      = timedOut;
                        iDataNext     = timedOut ? '0 : RamRData;
                        iDoneHartNext = hart;
                    end
                end else begin
                    cntNext = cnt + TIMEOUT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            owner     <= SIDE_I;
            lastGrant <= SIDE_D;
            squash    <= 1'b0;
            cnt       <= '0;
            hart      <= '0;
            IGrant    <= 1'b0;
            IDone     <= 1'b0;
            IErr      <= 1'b0;
            IData     <= '0;
            IDoneHart <= '0;
            DGrant    <= 1'b0;
            DDone     <= 1'b0;
            DErr      <= 1'b0;
            DRData    <= '0;
            DDoneHart <= '0;
            RamRead   <= 1'b0;
            RamWrite  <= 1'b0;
            RamAddr   <= '0;
            RamWData  <= '0;
            RamByteEn <= '0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            lastGrant <= lastGrantNext;
            squash    <= squashNext;
            cnt       <= cntNext;
            hart      <= hartNext;
            IGrant    <= iGrantNext;
            IDone     <= iDoneNext;
            IErr      <= iErrNext;
            IData     <= iDataNext;
            IDoneHart <= iDoneHartNext;
            DGrant    <= dGrantNext;
            DDone     <= dDoneNext;
            DErr      <= dErrNext;
            DRData    <= dRDataNext;
            DDoneHart <= dDoneHartNext;
            RamRead   <= ramReadNext;
            RamWrite  <= ramWriteNext;
            RamAddr   <= ramAddrNext;
            RamWData  <= ramWDataNext;
            RamByteEn <= ramByteEnNext;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. The expected behaviour is described per
// transaction: when a request is accepted, its grant, RAM-ready and completion
// cycles are computed from the chosen RAM latency, and every cycle's outputs
// follow from those cycle windows.
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nReset;
    logic        IReq, IFlush, DReq, DWe, RamReady;
    logic [31:0] IAddr, DAddr, DWData, RamRData;
    logic [1:0]  IHart, DHart;
    logic [3:0]  DByteEn;
    logic        IGrant, IDone, IErr, DGrant, DDone, DErr, RamRead, RamWrite;
    logic [31:0] IData, DRData, RamAddr, RamWData;
    logic [1:0]  IDoneHart, DDoneHart;
    logic [3:0]  RamByteEn;
    // outputs of the D-priority instance
    logic        pIGrant, pIDone, pIErr, pDGrant, pDDone, pDErr, pRamRead, pRamWrite;
    logic [31:0] pIData, pDRData, pRamAddr, pRamWData;
    logic [1:0]  pIDoneHart, pDDoneHart;
    logic [3:0]  pRamByteEn;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8), .D_PRIORITY(1'b0)) dut (
        .clk(clk), .nReset(nReset),
        .IReq(IReq), .IAddr(IAddr), .IHart(IHart), .IFlush(IFlush),
        .IGrant(IGrant), .IDone(IDone), .IErr(IErr), .IData(IData), .IDoneHart(IDoneHart),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DByteEn(DByteEn), .DHart(DHart),
        .DGrant(DGrant), .DDone(DDone), .DErr(DErr), .DRData(DRData), .DDoneHart(DDoneHart),
        .RamRead(RamRead), .RamWrite(RamWrite), .RamAddr(RamAddr), .RamWData(RamWData),
        .RamByteEn(RamByteEn), .RamReady(RamReady), .RamRData(RamRData));

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8), .D_PRIORITY(1'b1)) dutP (
        .clk(clk), .nReset(nReset),
        .IReq(IReq), .IAddr(IAddr), .IHart(IHart), .IFlush(IFlush),
        .IGrant(pIGrant), .IDone(pIDone), .IErr(pIErr), .IData(pIData), .IDoneHart(pIDoneHart),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DByteEn(DByteEn), .DHart(DHart),
        .DGrant(pDGrant), .DDone(pDDone), .DErr(pDErr), .DRData(pDRData), .DDoneHart(pDDoneHart),
        .RamRead(pRamRead), .RamWrite(pRamWrite), .RamAddr(pRamAddr), .RamWData(pRamWData),
        .RamByteEn(pRamByteEn), .RamReady(RamReady), .RamRData(RamRData));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // current transaction
    bit          curValid, curD, curWe, curErr, curSquash;
    int          curGrant, curReady, curDone;
    logic [31:0] curAddr, curWData, curRData;
    logic [3:0]  curBe;
    logic [1:0]  curHart;
    bit          lastD;

    // requesters
    bit          iPend, iTaken, dPend, dTaken, dWeR;
    int          iTakenCyc, dTakenCyc;
    logic [31:0] iA, dA, dWd;
    logic [1:0]  iH, dH;
    logic [3:0]  dBe;

    bit          autoReq, flushNext, readyNext, rdFixedOn;
    logic [31:0] rdFixed;
    int          latQ[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit inWait, input bit isDone);
        bit dn, inn, eRd, eWr;
        logic [31:0] rdExp;
        dn  = isDone && curD;
        inn = isDone && !curD && !curSquash;
        rdExp = (curErr || curWe) ? 32'h0 : curRData;
        eRd = inWait && !curWe;
        eWr = inWait && curWe;
        chk("IGrant", 32'(IGrant), 32'(curValid && !curD && cyc == curGrant));
        chk("DGrant", 32'(DGrant), 32'(curValid && curD && cyc == curGrant));
        chk("RamRead", 32'(RamRead), 32'(eRd));
        chk("RamWrite", 32'(RamWrite), 32'(eWr));
        if (inWait) begin
            chk("RamAddr", RamAddr, curAddr);
            chk("RamByteEn", 32'(RamByteEn), 32'(curBe));
            if (curWe) chk("RamWData", RamWData, curWData);
        end
        chk("IDone", 32'(IDone), 32'(inn));
        chk("IErr", 32'(IErr), 32'(inn && curErr));
        chk("IData", IData, inn ? rdExp : 32'h0);
        chk("IDoneHart", 32'(IDoneHart), inn ? 32'(curHart) : 32'h0);
        chk("DDone", 32'(DDone), 32'(dn));
        chk("DErr", 32'(DErr), 32'(dn && curErr));
        chk("DRData", DRData, dn ? rdExp : 32'h0);
        chk("DDoneHart", 32'(DDoneHart), dn ? 32'(curHart) : 32'h0);
    endtask

    task automatic model_reset();
        curValid = 0; curSquash = 0; curErr = 0; curWe = 0; curD = 0;
        lastD = 1;
        iPend = 0; iTaken = 0; dPend = 0; dTaken = 0;
        flushNext = 0; readyNext = 0;
        latQ.delete();
        IReq = 0; IFlush = 0; DReq = 0; DWe = 0; RamReady = 0;
        IAddr = '0; IHart = '0; DAddr = '0; DWData = '0; DByteEn = '0; DHart = '0;
        RamRData = '0;
    endtask

    task automatic reqI(input logic [31:0] a, input logic [1:0] h);
        iPend = 1; iTaken = 0; iA = a; iH = h;
    endtask

    task automatic reqD(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [1:0] h);
        dPend = 1; dTaken = 0; dWeR = we; dA = a; dWd = wd; dBe = be; dH = h;
    endtask

    // One clock: check this cycle's outputs, drive this cycle's inputs, then
    // decide what the coming edge does to the transaction bookkeeping.
    task automatic cycle();
        bit inWait, isDone, iC, dC, pickD;
        int lat;
        @(posedge clk); #1;
        cyc++;
        inWait = curValid && cyc >= curGrant && cyc < curDone;
        isDone = curValid && cyc == curDone;
        check_outputs(inWait, isDone);

        if (iTaken && cyc > iTakenCyc) begin iPend = 0; iTaken = 0; end
        if (dTaken && cyc > dTakenCyc) begin dPend = 0; dTaken = 0; end
        if (autoReq) begin
            if (!iPend && $urandom_range(0, 2) == 0)
                reqI($urandom, 2'($urandom_range(0, 3)));
            if (!dPend && $urandom_range(0, 2) == 0)
                reqD(1'($urandom_range(0, 1)), $urandom, $urandom,
                     4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        IReq = iPend; IAddr = iA; IHart = iH;
        DReq = dPend; DWe = dWeR; DAddr = dA; DWData = dWd; DByteEn = dBe; DHart = dH;
        IFlush = flushNext || (autoReq && $urandom_range(0, 11) == 0);
        flushNext = 0;
        RamRData = rdFixedOn ? rdFixed : $urandom;
        RamReady = (inWait && cyc == curReady) || readyNext ||
                   (autoReq && !inWait && $urandom_range(0, 7) == 0);
        readyNext = 0;

        if (inWait) begin
            if (!curD && IFlush) curSquash = 1;
            if (cyc == curReady) curRData = RamRData;
        end else begin
            iC = iPend && !iTaken && !IFlush;
            dC = dPend && !dTaken;
            if (iC || dC) begin
                pickD = dC && (!iC || !lastD);
                lat = (latQ.size() > 0) ? latQ.pop_front() : $urandom_range(1, TO + 3);
                curValid = 1; curD = pickD; curGrant = cyc + 1;
                curSquash = 0; curRData = '0;
                if (lat <= TO) begin
                    curReady = cyc + lat; curDone = cyc + 1 + lat; curErr = 0;
                end else begin
                    curReady = -1; curDone = cyc + 1 + TO; curErr = 1;
                end
                if (pickD) begin
                    curWe = dWeR; curAddr = dA; curWData = dWd; curBe = dBe; curHart = dH;
                    dTaken = 1; dTakenCyc = cyc + 1;
                end else begin
                    curWe = 0; curAddr = iA; curWData = '0; curBe = 4'b1111; curHart = iH;
                    iTaken = 1; iTakenCyc = cyc + 1;
                end
                lastD = pickD;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic doReset();
        nReset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0, 0);
        chk("rst RamAddr", RamAddr, 32'h0);
        chk("rst RamWData", RamWData, 32'h0);
        chk("rst RamByteEn", 32'(RamByteEn), 32'h0);
        nReset = 1;
    endtask

    initial begin
        autoReq = 0; rdFixedOn = 0; rdFixed = '0;
        iA = '0; iH = '0; dA = '0; dWd = '0; dBe = '0; dH = '0; dWeR = 0;
        doReset();

        // I read, RamReady in the third WAIT cycle
        reqI(32'h100, 2'd2); latQ.push_back(3);
        rdFixedOn = 1; rdFixed = 32'hDEADBEEF;
        cycle();
        cycle();
        chk("Iread grant", 32'(IGrant), 32'd1);
        chk("Iread addr", RamAddr, 32'h100);
        cycle(); cycle(); cycle();
        chk("Iread done", 32'(IDone), 32'd1);
        chk("Iread data", IData, 32'hDEADBEEF);
        chk("Iread hart", 32'(IDoneHart), 32'd2);
        rdFixedOn = 0;
        run(2);

        // D write
        reqD(1, 32'h2000, 32'h12345678, 4'b0011, 2'd1); latQ.push_back(2);
        cycle();
        cycle();
        chk("Dwr strobe", 32'(RamWrite), 32'd1);
        chk("Dwr be", 32'(RamByteEn), 32'h3);
        chk("Dwr data", RamWData, 32'h12345678);
        cycle(); cycle();
        chk("Dwr done", 32'(DDone), 32'd1);
        chk("Dwr rdata", DRData, 32'h0);
        chk("Dwr hart", 32'(DDoneHart), 32'd1);
        run(2);

        // tie straight after reset: round-robin picks I, D-priority picks D
        doReset();
        reqI(32'h40, 2'd0); reqD(0, 32'h80, 32'h0, 4'hF, 2'd3);
        latQ.push_back(1); latQ.push_back(1);
        cycle();
        cycle();
        chk("tie rr IGrant", 32'(IGrant), 32'd1);
        chk("tie pri DGrant", 32'(pDGrant), 32'd1);
        chk("tie pri IGrant", 32'(pIGrant), 32'd0);
        run(6);
        reqI(32'h44, 2'd1); reqD(0, 32'h84, 32'h0, 4'hF, 2'd2);
        latQ.push_back(2); latQ.push_back(2);
        run(10);

        // watchdog timeout with a D request waiting
        reqI(32'h300, 2'd1); latQ.push_back(TO + 1);
        cycle();
        reqD(0, 32'h400, 32'h0, 4'hF, 2'd2); latQ.push_back(1);
        run(TO);
        cycle();
        chk("to IDone", 32'(IDone), 32'd1);
        chk("to IErr", 32'(IErr), 32'd1);
        chk("to IData", IData, 32'h0);
        chk("to RamRead", 32'(RamRead), 32'd0);
        cycle();
        chk("to DGrant", 32'(DGrant), 32'd1);
        run(4);

        // RamReady in the last watchdog cycle completes normally
        reqI(32'h304, 2'd3); latQ.push_back(TO);
        cycle();
        run(TO);
        cycle();
        chk("edge IDone", 32'(IDone), 32'd1);
        chk("edge IErr", 32'(IErr), 32'd0);
        run(2);

        // flush during the I grant cycle with D waiting
        reqI(32'h500, 2'd3); latQ.push_back(3);
        cycle();
        reqD(0, 32'h600, 32'h0, 4'h5, 2'd0); latQ.push_back(2);
        flushNext = 1;
        cycle();
        run(2);
        cycle();
        chk("flush IDone", 32'(IDone), 32'd0);
        cycle();
        chk("flush DGrant", 32'(DGrant), 32'd1);
        run(5);

        // reset in the middle of WAIT
        reqI(32'h700, 2'd1); latQ.push_back(TO + 1);
        run(3);
        #2;
        nReset = 0;
        #1;
        chk("midrst RamRead", 32'(RamRead), 32'd0);
        chk("midrst RamAddr", RamAddr, 32'h0);
        chk("midrst IGrant", 32'(IGrant), 32'd0);
        model_reset();
        @(posedge clk); #1;
        nReset = 1;
        readyNext = 1;
        run(4);

        // randomized traffic on both sides
        autoReq = 1;
        run(3000);
        autoReq = 0;
        run(TO + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
